// File: rtl/axis_multichannel_distortion.sv
// axis_multichannel_distortion
// Three-stage AXI-Stream distortion for NUM_CH packed signed samples:
//   S1 pre-gain multiply, S2 floor shift + saturate, S3 waveshaper into the
//   output register. One global enable freezes every stage on back-pressure,
//   so beats are never dropped or duplicated. Mode, gain and threshold are
//   latched on the first beat of each packet and travel with the beat.
module axis_multichannel_distortion #(
    parameter int SAMPLE_W  = 24,
    parameter int NUM_CH    = 2,
    parameter int GAIN_W    = 16,
    parameter int GAIN_FRAC = 12
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic [1:0]                   cfg_mode,
    input  logic [GAIN_W-1:0]            cfg_gain,
    input  logic [SAMPLE_W-2:0]          cfg_threshold,
    input  logic [NUM_CH*SAMPLE_W-1:0]   s_axis_tdata,
    input  logic                         s_axis_tvalid,
    output logic                         s_axis_tready,
    input  logic                         s_axis_tlast,
    output logic [NUM_CH*SAMPLE_W-1:0]   m_axis_tdata,
    output logic                         m_axis_tvalid,
    input  logic                         m_axis_tready,
    output logic                         m_axis_tlast,
    output logic [31:0]                  clip_count,
    input  logic                         clip_count_clr
);
    localparam int DW = NUM_CH * SAMPLE_W;
    localparam int PW = SAMPLE_W + GAIN_W + 1;  // signed product width
    localparam int XW = SAMPLE_W + 2;           // shaper headroom (|x|, -T, knee sum)
    localparam int CW = $clog2(NUM_CH + 1);

    localparam logic [1:0] MODE_BYPASS = 2'd0;
    localparam logic [1:0] MODE_HARD   = 2'd1;
    localparam logic [1:0] MODE_SOFT   = 2'd2;
    localparam logic [1:0] MODE_ASYM   = 2'd3;

    localparam logic signed [PW-1:0] SMAX_P = PW'((64'sd1 <<< (SAMPLE_W - 1)) - 64'sd1);
    localparam logic signed [PW-1:0] SMIN_P = ~SMAX_P;
    localparam logic signed [XW-1:0] SMAX_X = XW'(SMAX_P);
    localparam logic signed [XW-1:0] SMIN_X = ~SMAX_X;

    logic                      en;
    logic                      acc;

    logic                      pkt_start_q;
    logic [1:0]                act_mode_q;
    logic [GAIN_W-1:0]         act_gain_q;
    logic [SAMPLE_W-2:0]       act_thr_q;
    logic [1:0]                beat_mode;
    logic [GAIN_W-1:0]         beat_gain;
    logic [SAMPLE_W-2:0]       beat_thr;

    logic                      s1_vld_q, s1_last_q;
    logic [DW-1:0]             s1_raw_q;
    logic [NUM_CH-1:0][PW-1:0] s1_prod_d, s1_prod_q;
    logic [1:0]                s1_mode_q;
    logic [SAMPLE_W-2:0]       s1_thr_q;

    logic                            s2_vld_q, s2_last_q;
    logic [DW-1:0]                   s2_raw_q;
    logic [NUM_CH-1:0][SAMPLE_W-1:0] s2_sat_d, s2_sat_q;
    logic [1:0]                      s2_mode_q;
    logic [SAMPLE_W-2:0]             s2_thr_q;

    logic                      m_vld_q, m_last_q;
    logic [DW-1:0]             m_data_d, m_data_q;
    logic [CW-1:0]             n_clip;
    logic [32:0]               clip_sum;
    logic [31:0]               clip_count_d, clip_count_q;

    // Floor shift out the gain fraction, then clamp into the sample range.
    function automatic logic [SAMPLE_W-1:0] sat_shift(input logic [PW-1:0] p);
        logic signed [PW-1:0] sh;
        logic signed [PW-1:0] r;
        sh = $signed(p) >>> GAIN_FRAC;
        r  = sh;
        if (sh > SMAX_P)      r = SMAX_P;
        else if (sh < SMIN_P) r = SMIN_P;
        return SAMPLE_W'(r);
    endfunction

    // Waveshaper: returns {altered, sample}. Bypass emits the raw input sample.
    function automatic logic [SAMPLE_W:0] shape(input logic [1:0]          mode,
                                                input logic [SAMPLE_W-1:0] xs,
                                                input logic [SAMPLE_W-1:0] raw,
                                                input logic [SAMPLE_W-2:0] thr);
        logic signed [XW-1:0] x, t, ax, y;
        logic                 clip;
        x    = XW'($signed(xs));
        t    = XW'(thr);
        ax   = x[XW-1] ? -x : x;
        y    = x;
        clip = 1'b0;
        case (mode)
            MODE_BYPASS: y = XW'($signed(raw));
            MODE_HARD: begin
                if (x > t)       begin y = t;  clip = 1'b1; end
                else if (x < -t) begin y = -t; clip = 1'b1; end
            end
            MODE_SOFT: begin
                if (ax > t) begin
                    y = t + ((ax - t) >>> 2);
                    if (x[XW-1]) y = -y;
                    if (y > SMAX_X)      y = SMAX_X;
                    else if (y < SMIN_X) y = SMIN_X;
                    clip = 1'b1;
                end
            end
            MODE_ASYM: begin
                if (x > t) begin y = t; clip = 1'b1; end
            end
        endcase
        return {clip, SAMPLE_W'(y)};
    endfunction

    assign en            = !m_vld_q || m_axis_tready;
    assign acc           = s_axis_tvalid && en;
    assign s_axis_tready = en;

    // First beat of a packet uses cfg_* straight from the ports.
    assign beat_mode = pkt_start_q ? cfg_mode      : act_mode_q;
    assign beat_gain = pkt_start_q ? cfg_gain      : act_gain_q;
    assign beat_thr  = pkt_start_q ? cfg_threshold : act_thr_q;

    // Packet-boundary tracking and active configuration capture.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            pkt_start_q <= 1'b1;
            act_mode_q  <= '0;
            act_gain_q  <= '0;
            act_thr_q   <= '0;
        end else if (acc) begin
            if (pkt_start_q) begin
                act_mode_q <= cfg_mode;
                act_gain_q <= cfg_gain;
                act_thr_q  <= cfg_threshold;
            end
            pkt_start_q <= s_axis_tlast;
        end
    end

    // S1 products: sample times zero-extended gain, signed.
    always_comb begin
        s1_prod_d = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            s1_prod_d[c] = PW'($signed(s_axis_tdata[c*SAMPLE_W +: SAMPLE_W]))
                         * PW'($signed({1'b0, beat_gain}));
        end
    end

    // S2 saturation of each scaled product.
    always_comb begin
        s2_sat_d = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            s2_sat_d[c] = sat_shift(s1_prod_q[c]);
        end
    end

    // S3 shaping plus count of channels altered in this beat.
    always_comb begin
        logic [SAMPLE_W:0] r;
        r        = '0;
        m_data_d = '0;
        n_clip   = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            r = shape(s2_mode_q, s2_sat_q[c], s2_raw_q[c*SAMPLE_W +: SAMPLE_W], s2_thr_q);
            m_data_d[c*SAMPLE_W +: SAMPLE_W] = r[SAMPLE_W-1:0];
            n_clip = n_clip + CW'(r[SAMPLE_W]);
        end
    end

    // Pipeline registers; everything holds while en is low.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            s1_vld_q  <= 1'b0;
            s1_last_q <= 1'b0;
            s1_raw_q  <= '0;
            s1_prod_q <= '0;
            s1_mode_q <= '0;
            s1_thr_q  <= '0;
            s2_vld_q  <= 1'b0;
            s2_last_q <= 1'b0;
            s2_raw_q  <= '0;
            s2_sat_q  <= '0;
            s2_mode_q <= '0;
            s2_thr_q  <= '0;
            m_vld_q   <= 1'b0;
            m_last_q  <= 1'b0;
            m_data_q  <= '0;
        end else if (en) begin
            s1_vld_q  <= acc;
            s1_last_q <= s_axis_tlast;
            s1_raw_q  <= s_axis_tdata;
            s1_prod_q <= s1_prod_d;
            s1_mode_q <= beat_mode;
            s1_thr_q  <= beat_thr;
            s2_vld_q  <= s1_vld_q;
            s2_last_q <= s1_last_q;
            s2_raw_q  <= s1_raw_q;
            s2_sat_q  <= s2_sat_d;
            s2_mode_q <= s1_mode_q;
            s2_thr_q  <= s1_thr_q;
            m_vld_q   <= s2_vld_q;
            m_last_q  <= s2_last_q;
            m_data_q  <= m_data_d;
        end
    end

    assign clip_sum = {1'b0, clip_count_q} + 33'(n_clip);

    // Saturating clip counter; clear wins over a same-cycle increment.
    always_comb begin
        clip_count_d = clip_count_q;
        if (clip_count_clr)         clip_count_d = '0;
        else if (en && s2_vld_q)    clip_count_d = clip_sum[32] ? '1 : clip_sum[31:0];
    end

    // Clip counter register.
    always_ff @(posedge clk) begin
        if (!resetn) clip_count_q <= '0;
        else         clip_count_q <= clip_count_d;
    end

    assign m_axis_tdata  = m_data_q;
    assign m_axis_tvalid = m_vld_q;
    assign m_axis_tlast  = m_last_q;
    assign clip_count    = clip_count_q;

endmodule

// File: tb/tb_axis_multichannel_distortion.sv
// Bench for axis_multichannel_distortion: per-beat arithmetic model feeding a
// scoreboard queue, checked on every output cycle, plus literal vectors.
module tb_axis_multichannel_distortion;
    localparam int SW = 24;
    localparam int NC = 2;
    localparam int GW = 16;
    localparam int GF = 12;
    localparam int DW = NC * SW;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic [1:0]    cfg_mode = '0;
    logic [GW-1:0] cfg_gain = '0;
    logic [SW-2:0] cfg_threshold = '0;
    logic [DW-1:0] s_axis_tdata = '0;
    logic          s_axis_tvalid = 1'b0;
    logic          s_axis_tready;
    logic          s_axis_tlast = 1'b0;
    logic [DW-1:0] m_axis_tdata;
    logic          m_axis_tvalid;
    logic          m_axis_tready = 1'b1;
    logic          m_axis_tlast;
    logic [31:0]   clip_count;
    logic          clip_count_clr = 1'b0;

    axis_multichannel_distortion #(.SAMPLE_W(SW), .NUM_CH(NC), .GAIN_W(GW), .GAIN_FRAC(GF)) dut (
        .clk(clk), .resetn(resetn),
        .cfg_mode(cfg_mode), .cfg_gain(cfg_gain), .cfg_threshold(cfg_threshold),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
        .clip_count(clip_count), .clip_count_clr(clip_count_clr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] data;
        bit            last;
        int            nclip;
    } beat_t;

    beat_t  exp_q[$];
    beat_t  got_q[$];
    int     total = 0;
    int     bad = 0;
    longint clip_sum = 0;
    bit     mdl_start = 1'b1;
    int     mm = 0;
    longint mg = 0, mt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One channel of the distortion rules in plain integer arithmetic.
    function automatic longint mdl_ch(input int mode, input longint g, input longint t,
                                      input longint s, output bit clipped);
        longint x, ax, y;
        clipped = 1'b0;
        if (mode == 0) return s;
        x = (s * g) >>> GF;
        if (x > 8388607)  x = 8388607;
        if (x < -8388608) x = -8388608;
        y = x;
        ax = (x < 0) ? -x : x;
        if (mode == 1) begin
            if (x > t)       begin y = t;  clipped = 1'b1; end
            else if (x < -t) begin y = -t; clipped = 1'b1; end
        end else if (mode == 2) begin
            if (ax > t) begin
                y = t + (ax - t) / 4;
                if (x < 0) y = -y;
                if (y > 8388607)  y = 8388607;
                if (y < -8388608) y = -8388608;
                clipped = 1'b1;
            end
        end else begin
            if (x > t) begin y = t; clipped = 1'b1; end
        end
        return y;
    endfunction

    // Model one accepted beat and queue its expected output.
    function automatic void push_model(input logic [DW-1:0] d, input bit last);
        beat_t       e;
        bit          c;
        logic [SW-1:0] smp;
        longint      y;
        if (mdl_start) begin
            mm = int'(cfg_mode);
            mg = longint'(cfg_gain);
            mt = longint'(cfg_threshold);
        end
        mdl_start = last;
        e.data = '0;
        e.last = last;
        e.nclip = 0;
        for (int ch = 0; ch < NC; ch++) begin
            smp = d[ch*SW +: SW];
            y = mdl_ch(mm, mg, mt, longint'($signed(smp)), c);
            e.data[ch*SW +: SW] = SW'(y);
            e.nclip += int'(c);
        end
        exp_q.push_back(e);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [DW-1:0] d, input bit last);
        int budget = 200;
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = d;
        s_axis_tlast  = last;
        forever begin
            @(negedge clk);
            if (s_axis_tready) break;
            budget--;
            if (budget == 0) break;
        end
        if (budget == 0) begin
            total++; bad++;
            $display("FAIL send_timeout: got tready=0 for 200 cycles, expected 1");
        end else begin
            push_model(d, last);
        end
        tick();
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            tick();
            n++;
        end
        check("drain_empty", 64'(exp_q.size()), 0);
        tick();
    endtask

    task automatic flush_model();
        exp_q.delete();
        got_q.delete();
        clip_sum = 0;
        mdl_start = 1'b1;
    endtask

    function automatic logic [DW-1:0] bp_beat(input int i);
        logic [SW-1:0] a, b;
        a = SW'(i * 1300000 - 5000000);
        b = SW'(32'h00F00000 - i * 700000);
        return {b, a};
    endfunction

    // Scoreboard: every mid-cycle with resetn high.
    always @(negedge clk) begin
        if (resetn) begin
            if (m_axis_tvalid) begin
                if (exp_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL out_unexpected: got beat 0x%0h, expected no beat", m_axis_tdata);
                end else begin
                    check("out_data", 64'(m_axis_tdata), 64'(exp_q[0].data));
                    check("out_last", 64'(m_axis_tlast), 64'(exp_q[0].last));
                    check("clip_count_live", 64'(clip_count), 64'(clip_sum + exp_q[0].nclip));
                    if (m_axis_tready) begin
                        got_q.push_back('{m_axis_tdata, m_axis_tlast, 0});
                        clip_sum += exp_q[0].nclip;
                        void'(exp_q.pop_front());
                    end
                end
            end else begin
                check("clip_count_idle", 64'(clip_count), 64'(clip_sum));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, expected finish within 50000 cycles");
        $fatal(1, "watchdog");
    end

    initial begin
        longint v;
        bit     c;
        logic [DW-1:0] d6, b1, b2;

        // Model pins
        v = mdl_ch(1, 'h2000, 'h080000, 'h050000, c);
        check("pin_hard", 64'(v), 64'('h080000));
        check("pin_hard_clip", 64'(c), 1);
        v = mdl_ch(2, 'h1000, 'h100000, -'h300000, c);
        check("pin_soft_neg", 64'(v), 64'(-'sh180000));
        v = mdl_ch(1, 'hF000, 'h7FFFFF, -'h800000, c);
        check("pin_sat_neg", 64'(v), 64'(-'sh7FFFFF));
        v = mdl_ch(3, 'h1000, 0, -5, c);
        check("pin_asym_neg", 64'(v), 64'(-'sd5));

        // Reset state
        repeat (3) tick();
        check("rst_tvalid", 64'(m_axis_tvalid), 0);
        check("rst_tdata", 64'(m_axis_tdata), 0);
        check("rst_tlast", 64'(m_axis_tlast), 0);
        check("rst_clip", 64'(clip_count), 0);
        resetn = 1'b1;
        tick();
        check("rst_tready", 64'(s_axis_tready), 1);

        // Bypass with latency probe
        cfg_mode = 2'd0; cfg_gain = 16'h3000; cfg_threshold = 23'h080000;
        b1 = {24'h123456, 24'hFEDCBA};
        b2 = {24'h800000, 24'h000001};
        send(b1, 1'b0);
        send(b2, 1'b1);
        s_axis_tvalid = 1'b0;
        check("lat_early", 64'(m_axis_tvalid), 0);
        tick();
        check("lat3_valid", 64'(m_axis_tvalid), 1);
        check("lat3_data", 64'(m_axis_tdata), 64'(b1));
        drain();
        check("byp_n", 64'(got_q.size()), 2);
        check("byp_d0", 64'(got_q[0].data), 64'(b1));
        check("byp_d1", 64'(got_q[1].data), 64'(b2));
        check("byp_l0", 64'(got_q[0].last), 0);
        check("byp_l1", 64'(got_q[1].last), 1);
        check("byp_clip", 64'(clip_count), 0);

        // Hard clip, gain 2.0
        got_q.delete();
        cfg_mode = 2'd1; cfg_gain = 16'h2000; cfg_threshold = 23'h080000;
        send({24'hFB0000, 24'h050000}, 1'b0);
        send({24'h000000, 24'h020000}, 1'b1);
        s_axis_tvalid = 1'b0;
        drain();
        check("hard_d0", 64'(got_q[0].data), 64'({24'hF80000, 24'h080000}));
        check("hard_d1", 64'(got_q[1].data), 64'({24'h000000, 24'h040000}));
        check("hard_clip", 64'(clip_count), 2);

        // Saturation then clamp to -T
        got_q.delete();
        cfg_mode = 2'd1; cfg_gain = 16'hF000; cfg_threshold = 23'h7FFFFF;
        send({24'h800000, 24'h7FFFFF}, 1'b1);
        s_axis_tvalid = 1'b0;
        drain();
        check("sat_d0", 64'(got_q[0].data), 64'({24'h800001, 24'h7FFFFF}));
        check("sat_clip", 64'(clip_count), 3);

        // Soft knee
        got_q.delete();
        cfg_mode = 2'd2; cfg_gain = 16'h1000; cfg_threshold = 23'h100000;
        send({24'hD00000, 24'h300000}, 1'b0);
        send({24'h000000, 24'h0F0000}, 1'b1);
        s_axis_tvalid = 1'b0;
        drain();
        check("soft_d0", 64'(got_q[0].data), 64'({24'hE80000, 24'h180000}));
        check("soft_d1", 64'(got_q[1].data), 64'({24'h000000, 24'h0F0000}));
        check("soft_clip", 64'(clip_count), 5);

        // Counter clear
        clip_count_clr = 1'b1;
        tick();
        clip_count_clr = 1'b0;
        clip_sum = 0;
        check("clr", 64'(clip_count), 0);

        // Back-pressure: 8 beats, downstream stalls 5 cycles
        got_q.delete();
        cfg_mode = 2'd2; cfg_gain = 16'h1800; cfg_threshold = 23'h200000;
        fork
            begin
                for (int i = 0; i < 8; i++) send(bp_beat(i), i == 7);
                s_axis_tvalid = 1'b0;
            end
            begin
                repeat (4) @(posedge clk);
                #1;
                m_axis_tready = 1'b0;
                for (int k = 0; k < 5; k++) begin
                    @(negedge clk);
                    check("bp_stall_tready", 64'(s_axis_tready), 0);
                end
                @(posedge clk);
                #1;
                m_axis_tready = 1'b1;
            end
        join
        drain();
        check("bp_n", 64'(got_q.size()), 8);
        for (int i = 0; i < 8; i++) check("bp_last", 64'(got_q[i].last), 64'(i == 7));

        // Config change mid-packet has no effect until next packet
        got_q.delete();
        d6 = {24'hF00000, 24'h100000};
        cfg_mode = 2'd1; cfg_gain = 16'h1000; cfg_threshold = 23'h040000;
        send(d6, 1'b0);
        cfg_mode = 2'd0;
        send(d6, 1'b0);
        send(d6, 1'b0);
        send(d6, 1'b1);
        send(d6, 1'b1);
        s_axis_tvalid = 1'b0;
        drain();
        for (int i = 0; i < 4; i++) check("cfg_pkt_clipped", 64'(got_q[i].data), 64'({24'hFC0000, 24'h040000}));
        check("cfg_next_bypass", 64'(got_q[4].data), 64'(d6));

        // Reset mid-packet drops in-flight beats
        cfg_mode = 2'd1;
        send(d6, 1'b0);
        send(d6, 1'b0);
        s_axis_tvalid = 1'b0;
        resetn = 1'b0;
        tick();
        check("mid_rst_tvalid", 64'(m_axis_tvalid), 0);
        check("mid_rst_clip", 64'(clip_count), 0);
        check("mid_rst_tdata", 64'(m_axis_tdata), 0);
        flush_model();
        resetn = 1'b1;
        tick();
        check("mid_rst_tready", 64'(s_axis_tready), 1);

        // Asymmetric clip and T=0 after reset
        cfg_mode = 2'd3; cfg_gain = 16'h1000; cfg_threshold = 23'h010000;
        send({24'hFE0000, 24'h020000}, 1'b1);
        cfg_mode = 2'd1; cfg_threshold = 23'h000000;
        send({24'hEDCBAA, 24'h123456}, 1'b1);
        cfg_mode = 2'd3;
        send({24'hFFFFF0, 24'h000005}, 1'b1);
        s_axis_tvalid = 1'b0;
        drain();
        check("asym_d", 64'(got_q[0].data), 64'({24'hFE0000, 24'h010000}));
        check("t0_hard", 64'(got_q[1].data), 64'({24'h000000, 24'h000000}));
        check("t0_asym", 64'(got_q[2].data), 64'({24'hFFFFF0, 24'h000000}));
        check("t0_clip", 64'(clip_count), 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/axis_multichannel_distortion.md
Name: axis_multichannel_distortion

Overview:
Parametrised, fully pipelined AXI-Stream distortion stage for N-channel packed audio words. Applies a per-packet programmable pre-gain, saturation and a selectable waveshaper (hard, soft-knee or asymmetric clip) to every channel. Honours full AXIS back-pressure. Counts clipped samples for level-monitoring software. Sits in the effects chain between the I2S receive path and downstream effects or the transmit FIFO.

Parameters:
SAMPLE_W, 24, signed sample width per channel
NUM_CH, 2, channels packed per beat, channel 0 in LSBs
GAIN_W, 16, unsigned gain width, fixed-point with GAIN_FRAC fractional bits
GAIN_FRAC, 12, gain fractional bits (1.0 = 2^GAIN_FRAC)

Ports:
clk  in  1  clock
resetn  in  1  synchronous active-low reset
cfg_mode  in  2  0 bypass, 1 hard clip, 2 soft clip, 3 asymmetric clip
cfg_gain  in  GAIN_W  pre-gain
cfg_threshold  in  SAMPLE_W-1  positive clip threshold T (unsigned)
s_axis_tdata  in  NUM_CH*SAMPLE_W  input samples
s_axis_tvalid  in  1  input valid
s_axis_tready  out  1  input ready
s_axis_tlast  in  1  end of packet
m_axis_tdata  out  NUM_CH*SAMPLE_W  processed samples
m_axis_tvalid  out  1  output valid
m_axis_tready  in  1  downstream ready
m_axis_tlast  out  1  end of packet, delayed with data
clip_count  out  32  saturating count of clipped samples
clip_count_clr  in  1  synchronous clear of clip_count

Behaviour:
- Reset: resetn is synchronous, active-low; clock clk. While resetn=0: m_axis_tvalid=0, m_axis_tdata=0, m_axis_tlast=0, clip_count=0, all stage valids cleared, pkt_start=1. s_axis_tready=1 from the first cycle after reset. A reset mid-packet drops all in-flight beats.
- Pipeline: 3 stages (S1 gain, S2 saturate, S3 shape/output register). Latency is exactly 3 cycles from input handshake to m_axis_tvalid when unstalled. Throughput is 1 beat/cycle.
- Stall: global enable en = !m_axis_tvalid | m_axis_tready. s_axis_tready = en (combinational). All stages hold when en=0. No beat is lost or duplicated. tvalid and tlast travel with the data.
- Config latch: pkt_start is set after reset and after any accepted beat with tlast. On an accepted beat with pkt_start=1, cfg_* is captured into active registers, and that beat already uses the new values. Mid-packet cfg changes have no effect until the next packet.
- S1: per channel, p = sample * {1'b0,gain}, signed, SAMPLE_W+GAIN_W+1 bits.
- S2: arithmetic shift right by GAIN_FRAC (floor), then saturate to [-2^(SAMPLE_W-1), 2^(SAMPLE_W-1)-1].
- S3 per channel, with x the saturated value and T the threshold:
  - mode 0: output the raw input sample. Gain is ignored, but latency is the same.
  - mode 1: clamp x to [-T, +T].
  - mode 2: if |x| <= T, output x. Otherwise output sign(x)*(T + ((|x|-T)>>2)), saturated to the signed range.
  - mode 3: positive x clamped to +T; negative x passes through unchanged.
- T=0 in modes 1 and 3 forces the affected half-waves to 0.
- clip_count: increments once per output-register load (en=1, S2 valid), adding the number of channels in that beat that were altered by clamp or knee (0..NUM_CH). Saturates at 0xFFFFFFFF. clip_count_clr has priority over increment in the same cycle.

Test Plan:
- Bypass (SAMPLE_W=24, NUM_CH=2), mode 0, gain 0x3000; beats {0xFEDCBA,0x123456}, {0x000001,0x800000} with tlast on beat 2 -> identical data out 3 cycles later; tlast on beat 2 only; clip_count=0.
- Hard clip, gain 0x2000 (2.0), T=0x080000; channel input 0x050000 -> 0x080000; 0xFB0000 -> 0xF80000; 0x020000 -> 0x040000; clip_count increments by 2 for that beat pair.
- Saturation, mode 1, gain 0xF000, T=0x7FFFFF; 0x7FFFFF -> 0x7FFFFF; 0x800000 -> 0x800001 (-T).
- Soft knee, mode 2, gain 0x1000, T=0x100000; 0x300000 -> 0x180000; 0xD00000 -> 0xE80000; 0x0F0000 -> 0x0F0000.
- Back-pressure: 8-beat packet with m_axis_tready held low 5 cycles mid-stream -> s_axis_tready low during the stall; output sequence and tlast position exactly match the reference model.
- Config boundary: switch mode 1 -> 0 during beat 2 of a 4-beat packet -> beats 1-4 are clipped and the next packet is bypassed. Assert resetn=0 mid-packet -> tvalid=0 next cycle and clip_count=0.
